// File: rtl/serv_imm_seq.sv
// serv_imm_seq: instruction fetch / pre-decode / 32-bit-cycle sequencer for
// the bit-serial SERV datapath. Fetches one word, latches the immediate
// shift-control pre-decode, waits for operands, then counts 32 bit cycles.
module serv_imm_seq (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_ibus_cyc,
    input  logic        i_ibus_ack,
    input  logic [31:0] i_ibus_rdt,
    output logic        o_wb_en,
    input  logic        i_rf_ready,
    input  logic        i_hold,
    output logic        o_cnt_en,
    output logic        o_cnt_done,
    output logic [4:0]  o_cnt,
    output logic [3:0]  o_ctrl,
    output logic        o_csr_imm_en
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2,
        S_RUN   = 2'd3
    } state_t;

    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_OPIMM  = 5'b00100;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_SYSTEM = 5'b11100;

    state_t      state;
    state_t      state_nxt;
    logic [4:0]  cnt;
    logic [3:0]  ctrl;
    logic        csr_imm;
    logic [4:0]  op;
    logic [3:0]  ctrl_dec;
    logic        csr_imm_dec;

    assign op = i_ibus_rdt[6:2];

    // Only the opcode and funct3[2] matter for the pre-decode; the rest of
    // the word belongs to the downstream decoder.
    logic unused_rdt;
    assign unused_rdt = ^{i_ibus_rdt[31:15], i_ibus_rdt[13:7], i_ibus_rdt[1:0]};

    // Strobes are decoded from registered state/counter, qualified by the
    // same-cycle input, so reset forces them low immediately.
    assign o_ibus_cyc   = (state == S_FETCH);
    assign o_wb_en      = o_ibus_cyc & i_ibus_ack;
    assign o_cnt_en     = (state == S_RUN) & ~i_hold;
    assign o_cnt_done   = o_cnt_en & (cnt == 5'd31);
    assign o_cnt        = cnt;
    assign o_ctrl       = ctrl;
    assign o_csr_imm_en = csr_imm;

    // Immediate-format pre-decode from the opcode field.
    always_comb begin
        ctrl_dec = 4'b0000;
        case (op)
            OP_LOAD, OP_OPIMM, OP_JALR: ctrl_dec = 4'b0010;
            OP_STORE:                   ctrl_dec = 4'b0011;
            OP_BRANCH:                  ctrl_dec = 4'b0101;
            OP_JAL:                     ctrl_dec = 4'b1000;
            OP_SYSTEM:                  ctrl_dec = 4'b0010;
            default:                    ctrl_dec = 4'b0000;
        endcase
        csr_imm_dec = (op == OP_SYSTEM) & i_ibus_rdt[14];
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = S_FETCH;
            S_FETCH: if (i_ibus_ack) state_nxt = S_WAIT;
            S_WAIT:  if (i_rf_ready) state_nxt = S_RUN;
            S_RUN:   if (o_cnt_done) state_nxt = S_FETCH;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Bit counter: advances only on enabled cycles, natural 5-bit wrap at done.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)      cnt <= 5'd0;
        else if (o_cnt_en) cnt <= cnt + 5'd1;
    end

    // Pre-decode fields captured on the accepted fetch, held until the next.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ctrl    <= 4'b0000;
            csr_imm <= 1'b0;
        end else if (o_wb_en) begin
            ctrl    <= ctrl_dec;
            csr_imm <= csr_imm_dec;
        end
    end

endmodule

// File: tb/tb_serv_imm_seq.sv
// tb_serv_imm_seq: directed + randomized bench with a scoreboard for the
// pre-decode fields and a phase-level reference model for the strobes.
module tb_serv_imm_seq;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_ibus_ack = 1'b0;
    logic [31:0] i_ibus_rdt = 32'd0;
    logic        i_rf_ready = 1'b0;
    logic        i_hold = 1'b0;
    logic        o_ibus_cyc, o_wb_en, o_cnt_en, o_cnt_done, o_csr_imm_en;
    logic [4:0]  o_cnt;
    logic [3:0]  o_ctrl;

    serv_imm_seq dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .o_ibus_cyc(o_ibus_cyc), .i_ibus_ack(i_ibus_ack), .i_ibus_rdt(i_ibus_rdt),
        .o_wb_en(o_wb_en), .i_rf_ready(i_rf_ready), .i_hold(i_hold),
        .o_cnt_en(o_cnt_en), .o_cnt_done(o_cnt_done), .o_cnt(o_cnt),
        .o_ctrl(o_ctrl), .o_csr_imm_en(o_csr_imm_en)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail = 0;
    logic [4:0] exp_q[$];
    logic [4:0] op_tab [9] = '{5'b00000, 5'b00100, 5'b11001, 5'b01000, 5'b11000,
                               5'b11011, 5'b01101, 5'b00101, 5'b11100};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: {ctrl[3:0], csr_imm} from the instruction word.
    function automatic logic [4:0] ref_dec(input logic [31:0] w);
        logic [4:0] op;
        logic [3:0] c;
        op = w[6:2];
        case (op)
            5'b00000, 5'b00100, 5'b11001: c = 4'b0010;
            5'b01000: c = 4'b0011;
            5'b11000: c = 4'b0101;
            5'b11011: c = 4'b1000;
            5'b11100: c = 4'b0010;
            default:  c = 4'b0000;
        endcase
        return {c, (op == 5'b11100) && w[14]};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int idx;
        w = $urandom;
        idx = $urandom_range(0, 9);
        if (idx < 9) w[6:2] = op_tab[idx];
        w[1:0] = 2'b11;
        return w;
    endfunction

    // Called right after inputs are driven: records an accepted fetch.
    task automatic push_if_fetch();
        if (i_rst_n && i_ibus_ack && o_ibus_cyc) exp_q.push_back(ref_dec(i_ibus_rdt));
    endtask

    // ---------------- monitor / reference phase model ----------------
    bit         m_idle, m_fetch, m_wait, m_run, pend;
    int         en_cnt;
    logic [4:0] cur_exp, pend_val;

    // Sample on the falling edge, away from the state update.
    always @(negedge i_clk) begin
        bit e_en, e_done, e_wb, n_fetch, n_wait, n_run;
        if (!i_rst_n) begin
            m_idle = 1; m_fetch = 0; m_wait = 0; m_run = 0;
            en_cnt = 0; cur_exp = 5'd0; pend = 0;
            exp_q.delete();
            chk("reset_outputs", 32'({o_ibus_cyc, o_wb_en, o_cnt_en, o_cnt_done,
                                      o_cnt, o_ctrl, o_csr_imm_en}), 32'd0);
        end else begin
            e_wb   = m_fetch && i_ibus_ack;
            e_en   = m_run && !i_hold;
            e_done = e_en && (en_cnt == 31);
            chk("ibus_cyc", 32'(o_ibus_cyc), 32'(m_fetch));
            chk("wb_en", 32'(o_wb_en), 32'(e_wb));
            chk("cnt_en", 32'(o_cnt_en), 32'(e_en));
            chk("cnt_done", 32'(o_cnt_done), 32'(e_done));
            chk("cnt", 32'(o_cnt), 32'(en_cnt));
            if (pend) cur_exp = pend_val;
            chk("ctrl", 32'(o_ctrl), 32'(cur_exp[4:1]));
            chk("csr_imm_en", 32'(o_csr_imm_en), 32'(cur_exp[0]));
            pend = 0;
            if (e_wb) begin
                if (exp_q.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
                else begin
                    pend_val = exp_q.pop_front();
                    pend = 1;
                end
            end
            n_fetch = m_idle || (m_fetch && !e_wb) || e_done;
            n_wait  = e_wb || (m_wait && !i_rf_ready);
            n_run   = (m_wait && i_rf_ready) || (m_run && !e_done);
            m_idle = 0; m_fetch = n_fetch; m_wait = n_wait; m_run = n_run;
            if (e_en) en_cnt = (en_cnt + 1) % 32;
        end
    end

    // ---------------- stimulus ----------------
    // mode: 0 no hold, 1 hold at cnt 5 (3 cyc) and cnt 31 (2 cyc),
    //       2 random hold, 3 async reset when cnt reaches 17.
    task automatic run_instr(input logic [31:0] w, input int ack_dly, input int rdy_dly,
                             input int mode, output bit reset_hit);
        int stage, nstage, fw, wc, h5, h31, ens, dones;
        bit fin;
        stage = 0; fw = 0; wc = 0; h5 = 0; h31 = 0; ens = 0; dones = 0; fin = 0;
        reset_hit = 0;
        for (int c = 0; c < 400 && !fin; c++) begin
            @(posedge i_clk); #1;
            i_ibus_ack = 1'b0;
            i_ibus_rdt = $urandom;
            i_rf_ready = ($urandom % 2) == 1;
            i_hold     = ($urandom % 2) == 1;
            nstage = stage;
            case (stage)
                0: begin
                    i_ibus_rdt = w;
                    if (o_ibus_cyc) begin
                        i_ibus_ack = (fw >= ack_dly);
                        fw++;
                    end
                    if (i_ibus_ack && o_ibus_cyc) nstage = 1;
                end
                1: begin
                    i_rf_ready = (wc >= rdy_dly);
                    wc++;
                    if (i_rf_ready) nstage = 2;
                end
                default: begin
                    i_ibus_ack = ($urandom % 3) == 0;
                    i_hold = 1'b0;
                    if (mode == 1) begin
                        if (o_cnt == 5'd5 && h5 < 3) begin i_hold = 1'b1; h5++; end
                        else if (o_cnt == 5'd31 && h31 < 2) begin i_hold = 1'b1; h31++; end
                    end else if (mode == 2) begin
                        i_hold = ($urandom % 4) == 0;
                    end else if (mode == 3 && o_cnt == 5'd17) begin
                        i_ibus_ack = 1'b0;
                        #2 i_rst_n = 1'b0;
                        #1;
                        chk("async_rst_strobes", 32'({o_ibus_cyc, o_wb_en, o_cnt_en, o_cnt_done}), 32'd0);
                        chk("async_rst_cnt", 32'(o_cnt), 32'd0);
                        chk("async_rst_ctrl", 32'({o_ctrl, o_csr_imm_en}), 32'd0);
                        @(posedge i_clk); @(posedge i_clk); #1;
                        i_rst_n = 1'b1;
                        @(negedge i_clk);
                        chk("restart_idle_cyc", 32'(o_ibus_cyc), 32'd0);
                        chk("restart_cnt", 32'(o_cnt), 32'd0);
                        @(negedge i_clk);
                        chk("restart_fetch_cyc", 32'(o_ibus_cyc), 32'd1);
                        reset_hit = 1;
                        return;
                    end
                end
            endcase
            push_if_fetch();
            @(negedge i_clk);
            if (stage == 2) begin
                if (i_hold) chk("held_no_en", 32'(o_cnt_en), 32'd0);
                if (o_cnt_en) ens++;
                if (o_cnt_done) begin dones++; fin = 1; end
            end
            stage = nstage;
        end
        chk("instr_complete", 32'(fin), 32'd1);
        chk("enables_per_instr", 32'(ens), 32'd32);
        chk("dones_per_instr", 32'(dones), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int fc, fwb, fd;
        bit rh;
        fc = 0; fwb = 0; fd = 0;
        repeat (3) @(negedge i_clk);
        chk("por_strobes", 32'({o_ibus_cyc, o_wb_en, o_cnt_en, o_cnt_done}), 32'd0);
        chk("por_state_regs", 32'({o_cnt, o_ctrl, o_csr_imm_en}), 32'd0);

        // Release with ack held high, operands ready, no hold.
        @(posedge i_clk); #1;
        i_rst_n = 1'b1; i_ibus_ack = 1'b1; i_rf_ready = 1'b1; i_hold = 1'b0;
        i_ibus_rdt = 32'h00C58593;
        for (int k = 1; k <= 60 && fd == 0; k++) begin
            if (k > 1) begin @(posedge i_clk); #1; end
            push_if_fetch();
            @(negedge i_clk);
            if (o_ibus_cyc && fc == 0) fc = k;
            if (o_wb_en && fwb == 0) fwb = k;
            if (o_cnt_done) fd = k;
        end
        chk("first_cyc_cycle", 32'(fc), 32'd2);
        chk("first_wb_cycle", 32'(fwb), 32'd2);
        chk("first_done_cycle", 32'(fd), 32'd35);

        run_instr(32'h00B12423, 0, 0, 0, rh);
        run_instr(32'hFE0008E3, 1, 2, 0, rh);
        run_instr(32'h008000EF, 0, 0, 1, rh);
        run_instr(32'h3400D073, 2, 10, 0, rh);
        run_instr(32'h34001073, 0, 0, 2, rh);
        run_instr(32'h00C58593, 0, 0, 3, rh);
        chk("reset_mid_run_taken", 32'(rh), 32'd1);
        run_instr(32'h00B12423, 0, 1, 0, rh);

        for (int i = 0; i < 40; i++)
            run_instr(rand_instr(), $urandom_range(0, 3), $urandom_range(0, 3), 2, rh);

        @(posedge i_clk); #1;
        i_ibus_ack = 1'b0;
        repeat (3) @(negedge i_clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
